// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry valid/ready stage that captures decoded operands,
// forwards EX/MEM and MEM/WB results into them, and keeps stalled operands current.
`timescale 1ns/1ps
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  alu_src,
    input  logic [3:0]            alu_ctrl_in,
    input  logic                  reg_write_in,
    input  logic                  flush,
    input  logic                  exmem_wr,
    input  logic                  memwb_wr,
    input  logic [ADDR_WIDTH-1:0] exmem_rd,
    input  logic [ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0] exmem_res,
    input  logic [DATA_WIDTH-1:0] memwb_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] op1,
    output logic [DATA_WIDTH-1:0] op2,
    output logic [3:0]            alu_ctrl,
    output logic [ADDR_WIDTH-1:0] rd_out,
    output logic                  reg_write_out
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
    logic [ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
    logic                  alu_src_q, alu_src_d, reg_write_q, reg_write_d;
    logic [3:0]            alu_ctrl_q, alu_ctrl_d;
    logic                  load;

    // EX/MEM is the younger result, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] base,
        input logic                  em_wr,
        input logic [ADDR_WIDTH-1:0] em_rd,
        input logic [DATA_WIDTH-1:0] em_res,
        input logic                  mw_wr,
        input logic [ADDR_WIDTH-1:0] mw_rd,
        input logic [DATA_WIDTH-1:0] mw_res
    );
        logic [DATA_WIDTH-1:0] r;
        r = base;
        if (a != '0) begin
            if (em_wr && em_rd == a)      r = em_res;
            else if (mw_wr && mw_rd == a) r = mw_res;
        end
        return r;
    endfunction

    assign in_ready = (state_q == EMPTY) | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_comb begin
        state_d     = state_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_d        = rd_q;
        alu_src_d   = alu_src_q;
        alu_ctrl_d  = alu_ctrl_q;
        reg_write_d = reg_write_q;

        if (load) begin
            rs1_val_d   = fwd(rs1_addr, rs1_data, exmem_wr, exmem_rd, exmem_res,
                              memwb_wr, memwb_rd, memwb_res);
            rs2_val_d   = fwd(rs2_addr, rs2_data, exmem_wr, exmem_rd, exmem_res,
                              memwb_wr, memwb_rd, memwb_res);
            imm_d       = imm;
            rs1_addr_d  = rs1_addr;
            rs2_addr_d  = rs2_addr;
            rd_d        = rd_addr;
            alu_src_d   = alu_src;
            alu_ctrl_d  = alu_ctrl_in;
            reg_write_d = reg_write_in;
        end else if (state_q == FULL) begin
            // Held operands track late writebacks so a stalled instruction never sees stale data.
            rs1_val_d = fwd(rs1_addr_q, rs1_val_q, exmem_wr, exmem_rd, exmem_res,
                            memwb_wr, memwb_rd, memwb_res);
            rs2_val_d = fwd(rs2_addr_q, rs2_val_q, exmem_wr, exmem_rd, exmem_res,
                            memwb_wr, memwb_rd, memwb_res);
        end

        if (flush)                             state_d = EMPTY;
        else if (load)                         state_d = FULL;
        else if (state_q == FULL && out_ready) state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_q        <= '0;
            alu_src_q   <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_q        <= rd_d;
            alu_src_q   <= alu_src_d;
            alu_ctrl_q  <= alu_ctrl_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign out_valid     = (state_q == FULL);
    assign op1           = rs1_val_q;
    assign op2           = alu_src_q ? imm_q : rs2_val_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign rd_out        = rd_q;
    assign reg_write_out = (state_q == FULL) & reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations plus a slot-level
// reference model compared against the DUT on every falling clock edge.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 0, in_ready, alu_src = 0, reg_write_in = 0, flush = 0;
    logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, exmem_res = 0, memwb_res = 0;
    logic [4:0]  rs1_addr = 0, rs2_addr = 0, rd_addr = 0, exmem_rd = 0, memwb_rd = 0;
    logic [3:0]  alu_ctrl_in = 0, alu_ctrl;
    logic        exmem_wr = 0, memwb_wr = 0, out_valid, out_ready = 0, reg_write_out;
    logic [31:0] op1, op2;
    logic [4:0]  rd_out;

    int errors = 0, checks = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .alu_ctrl_in(alu_ctrl_in), .reg_write_in(reg_write_in),
        .flush(flush), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd), .exmem_res(exmem_res), .memwb_res(memwb_res),
        .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2),
        .alu_ctrl(alu_ctrl), .rd_out(rd_out), .reg_write_out(reg_write_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the stage is a single slot holding one instruction record.
    typedef struct {
        logic        valid;
        logic [4:0]  a1, a2, rd;
        logic [31:0] v1, v2, imm;
        logic        src, rw;
        logic [3:0]  ctrl;
    } slot_t;
    slot_t m;

    function automatic logic [31:0] newest(input logic [4:0] a, input logic [31:0] dflt);
        if (a == 0) return dflt;
        if (exmem_wr && exmem_rd == a) return exmem_res;
        if (memwb_wr && memwb_rd == a) return memwb_res;
        return dflt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.valid = 0; m.v1 = 0; m.v2 = 0; m.imm = 0; m.src = 0; m.rw = 0; m.ctrl = 0; m.rd = 0;
            m.a1 = 0; m.a2 = 0;
        end else begin
            bit accepted, consumed;
            accepted = in_valid && (!m.valid || out_ready) && !flush;
            consumed = m.valid && out_ready;
            if (accepted) begin
                m.a1 = rs1_addr; m.a2 = rs2_addr; m.rd = rd_addr;
                m.v1 = newest(rs1_addr, rs1_data); m.v2 = newest(rs2_addr, rs2_data);
                m.imm = imm; m.src = alu_src; m.rw = reg_write_in; m.ctrl = alu_ctrl_in;
                m.valid = 1;
            end else begin
                if (m.valid) begin
                    m.v1 = newest(m.a1, m.v1);
                    m.v2 = newest(m.a2, m.v2);
                end
                if (consumed) m.valid = 0;
            end
            if (flush) m.valid = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_out_valid", out_valid, m.valid);
            check("mdl_in_ready", in_ready, !m.valid || out_ready);
            check("mdl_reg_write", reg_write_out, m.valid && m.rw);
            if (m.valid) begin
                check("mdl_op1", op1, m.v1);
                check("mdl_op2", op2, m.src ? m.imm : m.v2);
                check("mdl_alu_ctrl", alu_ctrl, m.ctrl);
                check("mdl_rd", rd_out, m.rd);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_op1"}, op1, 0);
        check({tag, "_op2"}, op2, 0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 0);
        check({tag, "_rd_out"}, rd_out, 0);
        check({tag, "_reg_write"}, reg_write_out, 0);
    endtask

    initial begin
        #3 check_zero("reset");
        #9 rst = 0;

        // Basic load with immediate operand
        in_valid = 1; rs1_addr = 1; rs1_data = 5; imm = 7; alu_src = 1; alu_ctrl_in = 0;
        rd_addr = 2; reg_write_in = 1; out_ready = 1;
        tick();
        check("load_valid", out_valid, 1); check("load_op1", op1, 5);
        check("load_op2", op2, 7); check("load_ctrl", alu_ctrl, 0);

        // Forwarding priority and x0 exclusion
        rs1_addr = 3; rs1_data = 32'h11; rs2_addr = 0; rs2_data = 32'h22; alu_src = 0;
        exmem_wr = 1; exmem_rd = 3; exmem_res = 32'hAA; memwb_wr = 1; memwb_rd = 3; memwb_res = 32'hBB;
        tick();
        check("fwd_exmem_wins", op1, 32'hAA); check("fwd_rs2_plain", op2, 32'h22);
        rs1_addr = 0; rs1_data = 32'h33;
        tick();
        check("fwd_x0", op1, 32'h33);
        rs1_addr = 3; exmem_wr = 0;
        tick();
        check("fwd_memwb", op1, 32'hBB);
        memwb_wr = 0;

        // Stall with operand refresh
        rs1_addr = 6; rs1_data = 32'h66; rs2_addr = 4; rs2_data = 32'h55; rd_addr = 9;
        tick();
        check("stall_loaded_op2", op2, 32'h55);
        in_valid = 1; rs2_data = 32'h77; out_ready = 0;
        memwb_wr = 1; memwb_rd = 4; memwb_res = 32'h1234;
        #1 check("stall_in_ready_comb", in_ready, 0);
        tick();
        check("stall_op2", op2, 32'h1234); check("stall_in_ready", in_ready, 0);
        check("stall_valid", out_valid, 1); check("stall_op1", op1, 32'h66);
        check("stall_rd", rd_out, 9);
        memwb_wr = 0;
        tick();
        check("stall_hold_op2", op2, 32'h1234);

        // Flush while full, with a competing offer
        flush = 1; rs1_data = 32'h99;
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0); check("flush_rw", reg_write_out, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        check("flush_not_captured", out_valid, 0);

        // Back-to-back stream
        rs1_addr = 5; alu_src = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; rs1_data = 100 + i; rd_addr = 5'(i + 1);
            #1 check("b2b_in_ready", in_ready, 1);
            tick();
            check("b2b_valid", out_valid, 1); check("b2b_op1", op1, 100 + i);
            check("b2b_rd", rd_out, i + 1);
        end
        in_valid = 0;
        tick();
        check("b2b_drain", out_valid, 0);

        // Async reset mid-stall, then reload
        in_valid = 1; rs1_data = 32'hDEAD; alu_ctrl_in = 4'd5; rd_addr = 7; reg_write_in = 1;
        tick();
        in_valid = 0; out_ready = 0;
        check("areset_pre_valid", out_valid, 1);
        #2 rst = 1;
        #1 check_zero("areset");
        #2 rst = 0;
        tick();
        check("areset_discard", out_valid, 0);
        in_valid = 1; rs1_data = 32'hBEEF; out_ready = 1;
        tick();
        check("areset_reload_op1", op1, 32'hBEEF); check("areset_reload_rw", reg_write_out, 1);

        // Mixed traffic checked against the model only
        for (int i = 0; i < 80; i++) begin
            in_valid = $urandom_range(0, 1); out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 7) == 0);
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            rd_addr = 5'($urandom_range(0, 31)); alu_src = $urandom_range(0, 1);
            alu_ctrl_in = 4'($urandom_range(0, 15)); reg_write_in = $urandom_range(0, 1);
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            exmem_wr = $urandom_range(0, 1); exmem_rd = 5'($urandom_range(0, 3)); exmem_res = $urandom;
            memwb_wr = $urandom_range(0, 1); memwb_rd = 5'($urandom_range(0, 3)); memwb_res = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
